// File: rtl/paket_alici.sv
// Frame receiver: hunts for SYNC, reads LEN, forwards the payload and checks the
// 2-byte trailer against an external crc16 engine that it also feeds and re-initialises.
module paket_alici #(
    parameter logic [7:0] SYNC        = 8'hA5,
    parameter int         PAYLOAD_MAX = 64,
    parameter int         ZAMAN_ASIMI = 1000
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic [7:0]  byte_i,
    input  logic        byte_gecerli_i,
    output logic        byte_hazir_o,
    output logic [7:0]  crc_byte_o,
    output logic        crc_etkin_o,
    output logic        crc_rstn_o,
    input  logic [15:0] crc16_i,
    output logic [7:0]  veri_o,
    output logic        veri_gecerli_o,
    output logic        paket_son_o,
    output logic        paket_tamam_o,
    output logic        paket_hata_o,
    output logic [1:0]  hata_kodu_o
);

    localparam int SW = $clog2(ZAMAN_ASIMI + 1);

    typedef enum logic [2:0] {
        BOSTA,
        UZUNLUK,
        VERI,
        CRC_Y,
        CRC_D,
        SIFIRLA
    } durum_t;

    durum_t        r_durum;
    durum_t        w_sonraki;
    logic [SW-1:0] r_bosta;
    logic [7:0]    r_kalan;
    logic [7:0]    r_crc_y;

    logic w_hazir;
    logic w_kabul;
    logic w_cerceve_ici;
    logic w_zaman_asimi;
    logic w_uzunluk_hata;
    logic w_crc_esit;

    assign w_hazir         = (r_durum != SIFIRLA);
    assign w_kabul         = byte_gecerli_i && w_hazir;
    assign w_cerceve_ici   = (r_durum == UZUNLUK) || (r_durum == VERI) ||
                             (r_durum == CRC_Y)   || (r_durum == CRC_D);
    // An accept in the limit cycle wins over the timeout.
    assign w_zaman_asimi   = w_cerceve_ici && !w_kabul && (r_bosta == SW'(ZAMAN_ASIMI - 1));
    assign w_uzunluk_hata  = (byte_i == 8'd0) || (byte_i > 8'(PAYLOAD_MAX));
    assign w_crc_esit      = ({r_crc_y, byte_i} == crc16_i);

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            r_durum <= BOSTA;
        end else begin
            r_durum <= w_sonraki;
        end
    end

    always_comb begin
        w_sonraki = r_durum;
        case (r_durum)
            BOSTA: begin
                if (w_kabul && (byte_i == SYNC)) w_sonraki = UZUNLUK;
            end
            UZUNLUK: begin
                if (w_kabul)            w_sonraki = w_uzunluk_hata ? SIFIRLA : VERI;
                else if (w_zaman_asimi) w_sonraki = SIFIRLA;
            end
            VERI: begin
                if (w_kabul && (r_kalan == 8'd1)) w_sonraki = CRC_Y;
                else if (w_zaman_asimi)           w_sonraki = SIFIRLA;
            end
            CRC_Y: begin
                if (w_kabul)            w_sonraki = CRC_D;
                else if (w_zaman_asimi) w_sonraki = SIFIRLA;
            end
            CRC_D: begin
                if (w_kabul || w_zaman_asimi) w_sonraki = SIFIRLA;
            end
            SIFIRLA: w_sonraki = BOSTA;
            default: w_sonraki = BOSTA;
        endcase
    end

    always_comb begin
        byte_hazir_o = w_hazir;
        crc_byte_o   = byte_i;
        crc_etkin_o  = w_kabul && (r_durum == VERI);
        crc_rstn_o   = rstn_i && (r_durum != SIFIRLA);
    end

    // Registered frame outputs, counters and the latched trailer high byte.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            veri_o         <= 8'd0;
            veri_gecerli_o <= 1'b0;
            paket_son_o    <= 1'b0;
            paket_tamam_o  <= 1'b0;
            paket_hata_o   <= 1'b0;
            hata_kodu_o    <= 2'b00;
            r_kalan        <= 8'd0;
            r_crc_y        <= 8'd0;
            r_bosta        <= '0;
        end else begin
            veri_gecerli_o <= 1'b0;
            paket_son_o    <= 1'b0;
            paket_tamam_o  <= 1'b0;
            paket_hata_o   <= 1'b0;
            hata_kodu_o    <= 2'b00;
            case (r_durum)
                UZUNLUK: begin
                    if (w_kabul) begin
                        if (w_uzunluk_hata) begin
                            paket_hata_o <= 1'b1;
                            hata_kodu_o  <= 2'b10;
                        end else begin
                            r_kalan <= byte_i;
                        end
                    end
                end
                VERI: begin
                    if (w_kabul) begin
                        veri_o         <= byte_i;
                        veri_gecerli_o <= 1'b1;
                        paket_son_o    <= (r_kalan == 8'd1);
                        r_kalan        <= r_kalan - 8'd1;
                    end
                end
                CRC_Y: begin
                    if (w_kabul) r_crc_y <= byte_i;
                end
                CRC_D: begin
                    if (w_kabul) begin
                        if (w_crc_esit) begin
                            paket_tamam_o <= 1'b1;
                        end else begin
                            paket_hata_o <= 1'b1;
                            hata_kodu_o  <= 2'b01;
                        end
                    end
                end
                default: ;
            endcase
            if (w_zaman_asimi) begin
                paket_hata_o <= 1'b1;
                hata_kodu_o  <= 2'b11;
            end
            if (!w_cerceve_ici || w_kabul) r_bosta <= '0;
            else                           r_bosta <= r_bosta + SW'(1);
        end
    end

endmodule

// File: tb/tb_paket_alici.sv
// Bench for paket_alici: behavioural crc16 engine, stream-parsing reference model
// and per-scenario tasks comparing emitted payload, pulses and their timing.
module tb_paket_alici;

    localparam int PAYLOAD_MAX = 64;
    localparam int ZAMAN_ASIMI = 1000;

    typedef struct packed {
        logic [7:0] d;
        logic       son;
    } pl_t;

    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic [7:0]  byte_i;
    logic        byte_gecerli_i;
    logic        byte_hazir_o;
    logic [7:0]  crc_byte_o;
    logic        crc_etkin_o;
    logic        crc_rstn_o;
    logic [15:0] crc16_i;
    logic [7:0]  veri_o;
    logic        veri_gecerli_o;
    logic        paket_son_o;
    logic        paket_tamam_o;
    logic        paket_hata_o;
    logic [1:0]  hata_kodu_o;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int rst_low_cnt = 0;
    int rst_low_cyc = -1;
    logic [7:0] str[$];
    pl_t exp_pl[$];
    pl_t obs_pl[$];
    int exp_ev[$];
    int obs_ev[$];
    int obs_ev_cyc[$];
    int acc_q[$];
    logic [15:0] eng_reg;

    paket_alici #(.SYNC(8'hA5), .PAYLOAD_MAX(PAYLOAD_MAX), .ZAMAN_ASIMI(ZAMAN_ASIMI)) dut (
        .clk_i(clk_i), .rstn_i(rstn_i), .byte_i(byte_i), .byte_gecerli_i(byte_gecerli_i),
        .byte_hazir_o(byte_hazir_o), .crc_byte_o(crc_byte_o), .crc_etkin_o(crc_etkin_o),
        .crc_rstn_o(crc_rstn_o), .crc16_i(crc16_i), .veri_o(veri_o),
        .veri_gecerli_o(veri_gecerli_o), .paket_son_o(paket_son_o),
        .paket_tamam_o(paket_tamam_o), .paket_hata_o(paket_hata_o), .hata_kodu_o(hata_kodu_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        r = c ^ {b, 8'h00};
        for (int k = 0; k < 8; k++) r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
        return r;
    endfunction

    // crc16 engine as seen by the DUT: combinational look-ahead while enabled.
    always @(posedge clk_i) begin
        if (!crc_rstn_o)      eng_reg <= 16'hFFFF;
        else if (crc_etkin_o) eng_reg <= crc_step(eng_reg, crc_byte_o);
    end
    assign crc16_i = crc_etkin_o ? crc_step(eng_reg, crc_byte_o) : eng_reg;

    always @(posedge clk_i) begin
        cyc++;
        #1;
        if (rstn_i) begin
            if (veri_gecerli_o) obs_pl.push_back('{d: veri_o, son: paket_son_o});
            if (paket_tamam_o) begin obs_ev.push_back(0); obs_ev_cyc.push_back(cyc); end
            if (paket_hata_o) begin obs_ev.push_back(int'(hata_kodu_o)); obs_ev_cyc.push_back(cyc); end
            if (!crc_rstn_o) begin rst_low_cnt++; rst_low_cyc = cyc; end
        end
    end

    function automatic logic [15:0] crc_of(input logic [7:0] p[$]);
        logic [15:0] c = 16'hFFFF;
        foreach (p[k]) c = crc_step(c, p[k]);
        return c;
    endfunction

    // Parse a whole byte stream by the frame rules: 0 = good frame, else error code.
    function automatic void model_stream(input logic [7:0] s[$]);
        int i = 0;
        int len;
        logic [7:0] p[$];
        exp_pl.delete();
        exp_ev.delete();
        while (i < s.size()) begin
            if (s[i] != 8'hA5) begin i++; continue; end
            i++;
            if (i >= s.size()) break;
            len = int'(s[i]);
            i++;
            if (len == 0 || len > PAYLOAD_MAX) begin exp_ev.push_back(2); continue; end
            p.delete();
            for (int k = 0; k < len && i < s.size(); k++) begin
                p.push_back(s[i]);
                exp_pl.push_back('{d: s[i], son: (k == len - 1)});
                i++;
            end
            if (i + 1 >= s.size()) break;
            exp_ev.push_back(({s[i], s[i+1]} == crc_of(p)) ? 0 : 1);
            i += 2;
        end
    endfunction

    function automatic void add_frame(input int len, input bit crc_bad);
        logic [7:0] p[$];
        logic [15:0] c;
        str.push_back(8'hA5);
        str.push_back(8'(len));
        if (len == 0 || len > PAYLOAD_MAX) return;
        for (int k = 0; k < len; k++) p.push_back(8'($urandom_range(0, 255)));
        c = crc_of(p) ^ (crc_bad ? 16'h0001 : 16'h0000);
        foreach (p[k]) str.push_back(p[k]);
        str.push_back(c[15:8]);
        str.push_back(c[7:0]);
    endfunction

    function automatic void clear_obs();
        obs_pl.delete();
        obs_ev.delete();
        obs_ev_cyc.delete();
        acc_q.delete();
        rst_low_cnt = 0;
        rst_low_cyc = -1;
    endfunction

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic drive_byte(input logic [7:0] b);
        int tries = 0;
        byte_i = b;
        byte_gecerli_i = 1'b1;
        while (!byte_hazir_o && tries < 8) begin @(negedge clk_i); tries++; end
        if (!byte_hazir_o) begin
            bad++;
            $display("[TB] FAIL ready_wait got=%0b exp=1", byte_hazir_o);
        end
        acc_q.push_back(cyc + 1);
        @(negedge clk_i);
        byte_gecerli_i = 1'b0;
    endtask

    task automatic run_stream(input int maxgap);
        model_stream(str);
        @(negedge clk_i);
        clear_obs();
        foreach (str[k]) begin
            if (maxgap > 0) repeat ($urandom_range(0, maxgap)) @(negedge clk_i);
            drive_byte(str[k]);
        end
        repeat (4) @(negedge clk_i);
    endtask

    task automatic test_reset();
        rstn_i = 1'b0;
        byte_i = 8'h00;
        byte_gecerli_i = 1'b0;
        repeat (3) @(negedge clk_i);
        total += 5;
        if ({veri_o, veri_gecerli_o, paket_son_o} !== 10'd0) begin
            bad++; $display("[TB] FAIL reset_veri got=%h exp=0", {veri_o, veri_gecerli_o, paket_son_o});
        end
        if ({paket_tamam_o, paket_hata_o, hata_kodu_o} !== 4'd0) begin
            bad++; $display("[TB] FAIL reset_pulses got=%h exp=0", {paket_tamam_o, paket_hata_o, hata_kodu_o});
        end
        if (crc_rstn_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_crc_rstn got=%b exp=0", crc_rstn_o); end
        if (byte_hazir_o !== 1'b1) begin bad++; $display("[TB] FAIL reset_ready got=%b exp=1", byte_hazir_o); end
        if (crc_etkin_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_etkin got=%b exp=0", crc_etkin_o); end
        rstn_i = 1'b1;
        @(negedge clk_i);
        total++;
        if (crc_rstn_o !== 1'b1) begin bad++; $display("[TB] FAIL release_crc_rstn got=%b exp=1", crc_rstn_o); end
    endtask

    task automatic test_good_frame();
        logic [7:0] s[$] = '{8'hA5, 8'h09, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'h29, 8'hB1};
        int last;
        str = s;
        add_frame($urandom_range(1, PAYLOAD_MAX), 1'b0);
        run_stream(0);
        last = acc_q[12];
        total += 7;
        if (obs_pl.size() < 9 || obs_pl[8] !== '{d: 8'h39, son: 1'b1} || obs_pl[7].son !== 1'b0) begin
            bad++; $display("[TB] FAIL std_last_payload count=%0d exp_last=39/son", obs_pl.size());
        end
        if (obs_ev.size() != 2 || obs_ev[0] != 0 || obs_ev[1] != 0) begin
            bad++; $display("[TB] FAIL std_events got=%p exp=0,0", obs_ev);
        end
        if (obs_ev_cyc.size() < 1 || obs_ev_cyc[0] != last) begin
            bad++; $display("[TB] FAIL std_tamam_timing got=%p exp=%0d", obs_ev_cyc, last);
        end
        if (rst_low_cnt != 2) begin bad++; $display("[TB] FAIL std_crc_rstn_cycles got=%0d exp=2", rst_low_cnt); end
        if (acc_q[13] != last + 2) begin bad++; $display("[TB] FAIL std_next_sync got=%0d exp=%0d", acc_q[13], last + 2); end
        if (obs_pl.size() != exp_pl.size()) begin bad++; $display("[TB] FAIL std_pl_count got=%0d exp=%0d", obs_pl.size(), exp_pl.size()); end
        if (obs_ev_cyc.size() < 2 || obs_ev_cyc[1] != acc_q[acc_q.size()-1]) begin
            bad++; $display("[TB] FAIL std_second_timing got=%p exp=%0d", obs_ev_cyc, acc_q[acc_q.size()-1]);
        end
        for (int k = 0; k < exp_pl.size() && k < obs_pl.size(); k++) begin
            total++;
            if (obs_pl[k] !== exp_pl[k]) begin
                bad++; $display("[TB] FAIL std_pl[%0d] got=%h exp=%h", k, obs_pl[k], exp_pl[k]);
            end
        end
    endtask

    task automatic test_single_byte();
        logic [7:0] s1[$] = '{8'hA5, 8'h01, 8'h00, 8'hE1, 8'hF0};
        logic [7:0] s2[$] = '{8'hA5, 8'h01, 8'h00, 8'hE1, 8'hF1};
        str = s1;
        run_stream(0);
        total += 2;
        if (obs_ev.size() != 1 || obs_ev[0] != 0) begin bad++; $display("[TB] FAIL single_ok got=%p exp=0", obs_ev); end
        if (obs_pl.size() != 1 || obs_pl[0] !== '{d: 8'h00, son: 1'b1}) begin
            bad++; $display("[TB] FAIL single_pl count=%0d exp=1", obs_pl.size());
        end
        str = s2;
        run_stream(0);
        total++;
        if (obs_ev.size() != 1 || obs_ev[0] != 1) begin bad++; $display("[TB] FAIL single_crc_err got=%p exp=1", obs_ev); end
    endtask

    task automatic test_length();
        int last;
        str.delete();
        add_frame(0, 1'b0);
        run_stream(0);
        last = acc_q[1];
        total += 3;
        if (obs_ev.size() != 1 || obs_ev[0] != 2) begin bad++; $display("[TB] FAIL len0 got=%p exp=2", obs_ev); end
        if (obs_ev_cyc.size() < 1 || obs_ev_cyc[0] != last) begin bad++; $display("[TB] FAIL len0_timing got=%p exp=%0d", obs_ev_cyc, last); end
        if (rst_low_cnt != 1) begin bad++; $display("[TB] FAIL len0_crc_rstn got=%0d exp=1", rst_low_cnt); end
        str.delete();
        add_frame(PAYLOAD_MAX + 1, 1'b0);
        run_stream(0);
        total++;
        if (obs_ev.size() != 1 || obs_ev[0] != 2 || obs_pl.size() != 0) begin
            bad++; $display("[TB] FAIL len_over got=%p pl=%0d exp=2 pl=0", obs_ev, obs_pl.size());
        end
        str.delete();
        add_frame(PAYLOAD_MAX, 1'b0);
        run_stream(1);
        total += 2;
        if (obs_ev.size() != 1 || obs_ev[0] != 0) begin bad++; $display("[TB] FAIL len_max got=%p exp=0", obs_ev); end
        if (obs_pl.size() != PAYLOAD_MAX || obs_pl[PAYLOAD_MAX-1].son !== 1'b1) begin
            bad++; $display("[TB] FAIL len_max_pl count=%0d exp=%0d", obs_pl.size(), PAYLOAD_MAX);
        end
    endtask

    task automatic test_garbage();
        logic [7:0] g[$] = '{8'h00, 8'hFF, 8'h5A};
        str = g;
        add_frame($urandom_range(1, 20), 1'b0);
        run_stream(2);
        total += 2;
        if (obs_ev.size() != 1 || obs_ev[0] != 0) begin bad++; $display("[TB] FAIL garbage_ev got=%p exp=0", obs_ev); end
        if (obs_pl.size() != exp_pl.size()) begin bad++; $display("[TB] FAIL garbage_pl got=%0d exp=%0d", obs_pl.size(), exp_pl.size()); end
        for (int k = 0; k < exp_pl.size() && k < obs_pl.size(); k++) begin
            total++;
            if (obs_pl[k] !== exp_pl[k]) begin bad++; $display("[TB] FAIL garbage_pl[%0d] got=%h exp=%h", k, obs_pl[k], exp_pl[k]); end
        end
    endtask

    task automatic test_timeout();
        logic [7:0] s[$] = '{8'hA5, 8'h03, 8'h11};
        logic [7:0] g[$] = '{8'hA5, 8'h01, 8'h00};
        int last;
        int waited = 0;
        @(negedge clk_i);
        clear_obs();
        foreach (s[k]) drive_byte(s[k]);
        last = acc_q[2];
        while (obs_ev.size() == 0 && waited < ZAMAN_ASIMI + 20) begin @(negedge clk_i); waited++; end
        total += 5;
        if (obs_ev.size() != 1 || obs_ev[0] != 3) begin bad++; $display("[TB] FAIL timeout_code got=%p exp=3", obs_ev); end
        if (obs_ev_cyc.size() < 1 || obs_ev_cyc[0] != last + ZAMAN_ASIMI) begin
            bad++; $display("[TB] FAIL timeout_timing got=%p exp=%0d", obs_ev_cyc, last + ZAMAN_ASIMI);
        end
        if (rst_low_cnt != 1 || rst_low_cyc != last + ZAMAN_ASIMI) begin
            bad++; $display("[TB] FAIL timeout_crc_rstn got=%0d@%0d exp=1@%0d", rst_low_cnt, rst_low_cyc, last + ZAMAN_ASIMI);
        end
        if (obs_pl.size() != 1 || obs_pl[0] !== '{d: 8'h11, son: 1'b0}) begin
            bad++; $display("[TB] FAIL timeout_pl count=%0d exp=1", obs_pl.size());
        end
        @(negedge clk_i);
        if (byte_hazir_o !== 1'b1) begin bad++; $display("[TB] FAIL timeout_ready got=%b exp=1", byte_hazir_o); end
        clear_obs();
        foreach (g[k]) drive_byte(g[k]);
        repeat (ZAMAN_ASIMI - 2) @(negedge clk_i);
        drive_byte(8'hE1);
        drive_byte(8'hF0);
        repeat (4) @(negedge clk_i);
        total++;
        if (obs_ev.size() != 1 || obs_ev[0] != 0) begin bad++; $display("[TB] FAIL gap_limit_minus1 got=%p exp=0", obs_ev); end
    endtask

    task automatic test_random_reset();
        str.delete();
        for (int f = 0; f < 6; f++) add_frame($urandom_range(1, PAYLOAD_MAX), ($urandom_range(0, 3) == 0));
        add_frame($urandom_range(PAYLOAD_MAX + 1, 255), 1'b0);
        add_frame($urandom_range(1, 8), 1'b0);
        run_stream(3);
        total += 2;
        if (obs_pl.size() != exp_pl.size()) begin bad++; $display("[TB] FAIL rnd_pl_count got=%0d exp=%0d", obs_pl.size(), exp_pl.size()); end
        if (obs_ev.size() != exp_ev.size()) begin bad++; $display("[TB] FAIL rnd_ev_count got=%0d exp=%0d", obs_ev.size(), exp_ev.size()); end
        for (int k = 0; k < exp_pl.size() && k < obs_pl.size(); k++) begin
            total++;
            if (obs_pl[k] !== exp_pl[k]) begin bad++; $display("[TB] FAIL rnd_pl[%0d] got=%h exp=%h", k, obs_pl[k], exp_pl[k]); end
        end
        for (int k = 0; k < exp_ev.size() && k < obs_ev.size(); k++) begin
            total++;
            if (obs_ev[k] != exp_ev[k]) begin bad++; $display("[TB] FAIL rnd_ev[%0d] got=%0d exp=%0d", k, obs_ev[k], exp_ev[k]); end
        end
        @(negedge clk_i);
        clear_obs();
        drive_byte(8'hA5);
        drive_byte(8'd10);
        for (int k = 0; k < 4; k++) drive_byte(8'($urandom_range(0, 255)));
        rstn_i = 1'b0;
        repeat (2) @(negedge clk_i);
        rstn_i = 1'b1;
        repeat (3) @(negedge clk_i);
        total++;
        if (obs_ev.size() != 0) begin bad++; $display("[TB] FAIL reset_mid_pulses got=%p exp=none", obs_ev); end
        str.delete();
        add_frame($urandom_range(1, 16), 1'b0);
        run_stream(2);
        total += 2;
        if (obs_ev.size() != 1 || obs_ev[0] != 0) begin bad++; $display("[TB] FAIL after_reset_frame got=%p exp=0", obs_ev); end
        if (obs_pl.size() != exp_pl.size()) begin bad++; $display("[TB] FAIL after_reset_pl got=%0d exp=%0d", obs_pl.size(), exp_pl.size()); end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_single_byte();
        test_length();
        test_garbage();
        test_timeout();
        test_random_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/paket_alici.md
# paket_alici

Byte-stream frame receiver that sits directly upstream of the `crc16` engine. It hunts for a sync byte, reads a length byte and forwards the payload downstream. Every accepted payload byte is also fed to `crc16` (CRC-16/CCITT-FALSE, init 0xFFFF). The block compares the 2-byte trailer against the engine result, flags good or bad frames, and re-initialises the engine between frames by pulsing its reset.

## Interface
- `SYNC`, 8'hA5: frame start byte.
- `PAYLOAD_MAX`, 64: maximum payload length, legal range 1..255.
- `ZAMAN_ASIMI`, 1000: idle-cycle limit between bytes inside a frame.

- `clk_i` in 1: single clock.
- `rstn_i` in 1: reset, synchronous, active-low.
- `byte_i` in 8: incoming byte.
- `byte_gecerli_i` in 1: `byte_i` valid.
- `byte_hazir_o` out 1: ready. A byte is accepted when valid and ready are both high.
- `crc_byte_o` out 8: byte to `crc16.byte_i`.
- `crc_etkin_o` out 1: to `crc16.etkin_i`.
- `crc_rstn_o` out 1: to `crc16.rstn_i`.
- `crc16_i` in 16: from `crc16.crc16_o`.
- `veri_o` out 8: payload byte.
- `veri_gecerli_o` out 1: payload byte valid, one-cycle pulse per byte, no backpressure.
- `paket_son_o` out 1: marks the last payload byte; qualified by `veri_gecerli_o`.
- `paket_tamam_o` out 1: frame OK, one-cycle pulse.
- `paket_hata_o` out 1: frame error, one-cycle pulse.
- `hata_kodu_o` out 2: error code, valid with `paket_hata_o`. 01 = CRC mismatch, 10 = illegal length, 11 = timeout.

## Operation
- Frame format on the wire: `SYNC`, LEN, LEN payload bytes, CRC high byte, CRC low byte.
- CRC coverage: payload bytes only.
- States:
  - BOSTA: ready = 1. Bytes other than `SYNC` are discarded silently. `SYNC` moves to UZUNLUK.
  - UZUNLUK: ready = 1. LEN is latched.
    - LEN = 0 or LEN > `PAYLOAD_MAX`: error code 10, go to SIFIRLA.
    - Otherwise: load the remaining counter with LEN, go to VERI.
  - VERI: ready = 1.
    - Each accepted byte: `crc_etkin_o` = 1, the byte is forwarded, the counter is decremented.
    - When the counter reaches 1 on accept: `paket_son_o` is set and the state moves to CRC_Y.
  - CRC_Y: ready = 1. The accepted byte is latched as the expected high byte. Go to CRC_D.
  - CRC_D: ready = 1. On accept, compare {high byte, `byte_i`} with `crc16_i`.
    - Equal: `paket_tamam_o` pulse.
    - Not equal: error code 01.
    - Either way, go to SIFIRLA.
  - SIFIRLA: exactly one cycle. `crc_rstn_o` = 0, ready = 0. Go to BOSTA.
- CRC engine connection (combinational):
  - `crc_byte_o` = `byte_i`.
  - `crc_etkin_o` = accept AND state == VERI.
  - `crc_rstn_o` = `rstn_i` AND (state != SIFIRLA).
- Engine behaviour relied on: `crc16_o` is combinational and reflects the register plus the current byte when enabled. In CRC_Y and CRC_D the enable is low, so `crc16_i` holds the final payload CRC.
- Timeout:
  - The idle counter clears on every accept and on entry to UZUNLUK.
  - It increments each cycle without an accept in UZUNLUK, VERI, CRC_Y and CRC_D.
  - On reaching `ZAMAN_ASIMI`: error code 11, go to SIFIRLA.
  - A byte accepted in the same cycle the limit would be reached takes priority, and the counter clears.
- Error pulses abort the frame. Payload bytes already emitted are not retracted. The downstream consumer discards the frame on `paket_hata_o`.
- A `SYNC` value appearing inside LEN, payload or CRC fields is treated as data; there is no resync.

## Timing
- Reset (`rstn_i` low at a clock edge): state becomes BOSTA.
  - Outputs after reset: `veri_o` = 0, `veri_gecerli_o` = 0, `paket_son_o` = 0, `paket_tamam_o` = 0, `paket_hata_o` = 0, `hata_kodu_o` = 0.
  - Counters are cleared.
  - `crc_rstn_o` follows `rstn_i`, so the engine is reset together with this block.
  - Reset mid-frame drops the frame with no pulses.
- `byte_hazir_o` is decoded from state only. It is low only in SIFIRLA and never depends on `byte_gecerli_i`.
- Registered outputs, each one cycle after the relevant accept:
  - `veri_o`, `veri_gecerli_o` and `paket_son_o`: one cycle after the payload byte is accepted.
  - `paket_tamam_o`, and `paket_hata_o` with code 01: one cycle after the CRC low byte is accepted.
  - Length error (code 10): one cycle after the LEN byte.
  - Timeout (code 11): the cycle after the limit is reached.
- The next `SYNC` is accepted at the earliest 2 cycles after the CRC low byte: one SIFIRLA cycle, then BOSTA.
- Back-to-back valid bytes are accepted every cycle in all states except SIFIRLA.

## Test plan
- Good frame, bytes valid every cycle: A5, 09, "123456789" (0x31..0x39), 29, B1.
  - Nine `veri_gecerli_o` pulses; `paket_son_o` on 0x39.
  - `paket_tamam_o` pulse 1 cycle after 0xB1.
  - `crc_rstn_o` low for exactly one cycle, then a second frame is accepted correctly.
- Single byte: A5, 01, 00, E1, F0 → `paket_tamam_o`. Same frame with trailer E1, F1 → `paket_hata_o`, code 01.
- Length boundaries:
  - LEN = 0 → code 10.
  - LEN = `PAYLOAD_MAX`+1 → code 10.
  - LEN = `PAYLOAD_MAX` with a correct CRC → `paket_tamam_o`.
- Garbage before sync: 00, FF, 5A, then a good frame → only the good frame is reported.
- Timeout: A5, 03, 11, then idle for `ZAMAN_ASIMI` cycles → code 11 pulse, `crc_rstn_o` pulse, BOSTA. An idle gap of `ZAMAN_ASIMI`−1 inside a good frame does not trigger a timeout.
- Random valid gaps plus `rstn_i` asserted mid-payload → no pulses, and the next good frame passes.
